// File: rtl/sad_min_tracker.sv
// sad_min_tracker
//   Streaming minimum-SAD search. Reduces a window of WINDOW_COUNT
//   candidates to the best SAD (with its row/column) and the second-best
//   SAD, then offers the result through a valid/ready handshake.
//
// Ports
//   Clk              sole clock, rising edge
//   Rst              synchronous active-high reset
//   Start            opens a new window (honoured in IDLE only)
//   InValid/InReady  candidate handshake
//   InSAD            candidate SAD
//   InRow/InColumn   candidate coordinates
//   OutValid/OutReady result handshake
//   MinSADOut        best SAD
//   MinSADRowOut/MinSADColumnOut  coordinates of best SAD
//   SecondMinSADOut  second-best SAD
//   CandidateCount   candidates accepted in the current window
//   Busy             unit is not idle
module sad_min_tracker #(
    parameter int unsigned SAD_WIDTH    = 32,
    parameter int unsigned COORD_WIDTH  = 8,
    parameter int unsigned WINDOW_COUNT = 256,
    parameter int unsigned TIE_MODE     = 0
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Start,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [SAD_WIDTH-1:0]   InSAD,
    input  logic [COORD_WIDTH-1:0] InRow,
    input  logic [COORD_WIDTH-1:0] InColumn,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [SAD_WIDTH-1:0]   MinSADOut,
    output logic [COORD_WIDTH-1:0] MinSADRowOut,
    output logic [COORD_WIDTH-1:0] MinSADColumnOut,
    output logic [SAD_WIDTH-1:0]   SecondMinSADOut,
    output logic [15:0]            CandidateCount,
    output logic                   Busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [15:0] LAST_INDEX = 16'(WINDOW_COUNT - 1);

    state_t state;
    state_t state_next;

    logic accept;
    logic last_accept;
    logic beats_min;
    logic beats_second;

    assign accept      = InValid && InReady;
    assign last_accept = accept && (CandidateCount == LAST_INDEX);

    // TIE_MODE 1 lets an equal later candidate displace the stored one.
    always_comb begin
        if (TIE_MODE != 0) begin
            beats_min    = (InSAD <= MinSADOut);
            beats_second = (InSAD <= SecondMinSADOut);
        end else begin
            beats_min    = (InSAD < MinSADOut);
            beats_second = (InSAD < SecondMinSADOut);
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start)                state_next = ACCUM;
            ACCUM:   if (last_accept)          state_next = HOLD;
            HOLD:    if (OutValid && OutReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        InReady  = (state == ACCUM);
        OutValid = (state == HOLD);
        Busy     = (state != IDLE);
    end

    // Result datapath: changes only on Start (from IDLE) or on an accept,
    // so results stay frozen through HOLD and IDLE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            MinSADOut       <= '1;
            SecondMinSADOut <= '1;
            MinSADRowOut    <= '0;
            MinSADColumnOut <= '0;
            CandidateCount  <= '0;
        end else if ((state == IDLE) && Start) begin
            MinSADOut       <= '1;
            SecondMinSADOut <= '1;
            MinSADRowOut    <= '0;
            MinSADColumnOut <= '0;
            CandidateCount  <= '0;
        end else if (accept) begin
            CandidateCount <= CandidateCount + 16'd1;
            if (beats_min) begin
                SecondMinSADOut <= MinSADOut;
                MinSADOut       <= InSAD;
                MinSADRowOut    <= InRow;
                MinSADColumnOut <= InColumn;
            end else if (beats_second) begin
                SecondMinSADOut <= InSAD;
            end
        end
    end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Streaming minimum-SAD search unit for the motion-estimation datapath. It accepts one SAD candidate per cycle with its block row and column, and tracks the best and second-best SAD over a search window of WINDOW_COUNT candidates. It then presents the window result through a valid/ready handshake. It replaces pairwise comparator trees: one instance reduces a whole search window sequentially, with configurable widths, window depth and tie-break policy.

## Interface
- SAD_WIDTH, 32: width of SAD values.
- COORD_WIDTH, 8: width of row/column coordinates.
- WINDOW_COUNT, 256: candidates per search window; legal range 2..65535.
- TIE_MODE, 0: 0 = on equal SAD keep the earlier candidate; 1 = the later candidate replaces it.
- Clk  input  1  sole clock; all logic is rising-edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse that opens a new window; honoured only in IDLE.
- InValid  input  1  candidate present.
- InReady  output  1  unit accepts a candidate this cycle.
- InSAD  input  SAD_WIDTH  candidate SAD.
- InRow, InColumn  input  COORD_WIDTH  candidate coordinates.
- OutValid  output  1  window result valid.
- OutReady  input  1  consumer accepts the result.
- MinSADOut  output  SAD_WIDTH  best SAD.
- MinSADRowOut, MinSADColumnOut  output  COORD_WIDTH  coordinates of best SAD.
- SecondMinSADOut  output  SAD_WIDTH  second-best SAD.
- CandidateCount  output  16  candidates accepted in the current window.
- Busy  output  1  state is not IDLE.

## Operation
- Three states: IDLE, ACCUM, HOLD.
  - IDLE → ACCUM on Start. On that edge:
    - MinSADOut and SecondMinSADOut load all-ones.
    - Coordinates load 0.
    - CandidateCount loads 0.
  - ACCUM → HOLD on the edge that accepts candidate number WINDOW_COUNT.
  - HOLD → IDLE on the edge where OutValid && OutReady.
- Accept = InValid && InReady. InReady = (state == ACCUM); it is independent of InValid.
- Update rule on accept. Let "better" mean `<` if TIE_MODE=0 and `<=` if TIE_MODE=1.
  - If InSAD is better than Min: Second ← Min; Min, Row, Col ← candidate.
  - Else if InSAD is better than Second: Second ← InSAD.
  - Otherwise nothing changes.
- Comparisons are unsigned over the full SAD_WIDTH; there is no saturation.
- CandidateCount increments on every accept. It stays frozen in HOLD and IDLE until the next Start.
- All result outputs hold steady throughout HOLD and IDLE; they change only on accepts or on Start.
- Start is ignored in ACCUM and HOLD; no restart occurs.
- InValid, InSAD, InRow and InColumn are ignored outside ACCUM.
- Reset values:
  - State = IDLE.
  - InReady = 0, OutValid = 0, Busy = 0.
  - MinSADOut and SecondMinSADOut = all-ones.
  - Coordinates = 0.
  - CandidateCount = 0.
- Reset in any state, including mid-window or in HOLD with OutValid high, aborts immediately to the reset values. The partial result is discarded.

## Timing
- Start at edge t: InReady = 1 from cycle t+1.
- Each accept is registered at its edge. Outputs reflect that candidate in the following cycle.
- The last accept at edge t gives OutValid = 1 in cycle t+1, with final results. Latency from last candidate to result is 1 cycle.
- InReady drops in the same cycle OutValid rises, so no extra candidate can be accepted.
- OutValid stays high until the handshake edge, then is 0 in the next cycle. The earliest new Start is honoured in the cycle after the handshake.
- Throughput: one candidate per cycle with continuous InValid. A window takes WINDOW_COUNT + 2 cycles from Start to IDLE when OutReady is held high.
- Gaps in InValid stall the window without limit; no timeout.

## Test plan
- **Reset state.** Rst high for 2 cycles → InReady = 0, OutValid = 0, MinSADOut = 0xFFFFFFFF, CandidateCount = 0.
- **Basic window.** WINDOW_COUNT = 4, Start, then SADs 50@(1,1), 20@(2,3), 35@(4,4), 90@(5,0) back-to-back → in the cycle after the 4th accept, OutValid = 1, MinSADOut = 20 at (2,3), SecondMinSADOut = 35, CandidateCount = 4.
- **Tie policy.** SADs 7@(0,0) then 7@(9,9), rest larger:
  - TIE_MODE = 0 → best at (0,0), SecondMinSADOut = 7.
  - TIE_MODE = 1 → best at (9,9), SecondMinSADOut = 7.
- **Back-pressure and gaps.** InValid toggled 1-0-1-0 and OutReady held 0 for 5 cycles after the result → OutValid stays high with stable outputs, InReady = 0 throughout, no 5th candidate accepted. OutReady = 1 → IDLE the next cycle.
- **Ignored Start.** Start pulsed mid-window after 2 accepts → CandidateCount continues to 3 and 4; results unchanged by the pulse.
- **Reset mid-window.** Rst after 2 accepts (MinSADOut = 20) → next cycle all outputs at reset values. A fresh Start and window produces a correct result independent of the aborted data.
